// File: rtl/card_draw_multi.sv
// card_draw_multi: draws draw_cnt distinct random cards from an availability bitmap.
// Inputs : clk, rst (async, active-high), interboard_rst (sync, active-high),
//          draw_req pulse with draw_cnt and available_card sampled alongside it.
// Outputs: ready (IDLE), card_valid/card_idx (one pulse per card),
//          done (request complete), empty_err (pool ran out, pulses with done).
// Optional: define DRAW_SEED_LOAD_EN to add seed_load/seed_val for LFSR reload.
module card_draw_multi #(
    parameter int                N_CARDS = 106,
    parameter int                IDX_W   = 7,
    parameter int                CNT_W   = 4,
    parameter int                LFSR_W  = 16,
    parameter logic [LFSR_W-1:0] SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               interboard_rst,
    input  logic               draw_req,
    input  logic [CNT_W-1:0]   draw_cnt,
    input  logic [N_CARDS-1:0] available_card,
`ifdef DRAW_SEED_LOAD_EN
    input  logic               seed_load,
    input  logic [LFSR_W-1:0]  seed_val,
`endif
    output logic               ready,
    output logic               card_valid,
    output logic [IDX_W-1:0]   card_idx,
    output logic               done,
    output logic               empty_err
);

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        MOD,
        SCAN,
        FIN
    } state_t;

    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_CARDS - 1);
    localparam logic [IDX_W-1:0] I_ONE = IDX_W'(1);
    localparam logic [IDX_W:0]   T_ONE = (IDX_W + 1)'(1);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    state_t               state_q, state_d;
    logic [N_CARDS-1:0]   pool_q, pool_d;
    logic [CNT_W-1:0]     remaining_q, remaining_d;
    logic [IDX_W-1:0]     avail_cnt_q, avail_cnt_d;
    logic [IDX_W:0]       target_q, target_d;
    logic [IDX_W-1:0]     pos_q, pos_d;
    logic                 load_q, load_d;
    logic                 err_q, err_d;
    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic                 card_valid_q, card_valid_d;
    logic [IDX_W-1:0]     card_idx_q, card_idx_d;
    logic                 done_q, done_d;
    logic                 empty_err_q, empty_err_d;
    logic                 fb;

    always_comb begin
        state_d      = state_q;
        pool_d       = pool_q;
        remaining_d  = remaining_q;
        avail_cnt_d  = avail_cnt_q;
        target_d     = target_q;
        pos_d        = pos_q;
        load_d       = load_q;
        err_d        = err_q;
        card_valid_d = 1'b0;
        card_idx_d   = card_idx_q;
        done_d       = 1'b0;
        empty_err_d  = 1'b0;

        // Taps give x^16+x^15+x^13+x^4+1 at the default width.
        fb = lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-2]
           ^ lfsr_q[LFSR_W-4] ^ lfsr_q[3];
        lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
`ifdef DRAW_SEED_LOAD_EN
        // A zero seed would lock the LFSR, so fall back to SEED.
        if (seed_load) begin
            lfsr_d = (seed_val == '0) ? SEED : seed_val;
        end
`endif

        unique case (state_q)
            IDLE: begin
                if (draw_req) begin
                    pool_d      = available_card;
                    remaining_d = draw_cnt;
                    avail_cnt_d = '0;
                    target_d    = '0;
                    pos_d       = '0;
                    state_d     = (draw_cnt == '0) ? FIN : COUNT;
                end
            end
            COUNT: begin
                avail_cnt_d = avail_cnt_q
                            + {{(IDX_W-1){1'b0}}, pool_q[pos_q]};
                if (pos_q == LAST) begin
                    pos_d   = '0;
                    load_d  = 1'b1;
                    state_d = MOD;
                end else begin
                    pos_d = pos_q + I_ONE;
                end
            end
            MOD: begin
                // First cycle samples the LFSR; later cycles reduce
                // target modulo avail_cnt one subtraction at a time.
                if (load_q) begin
                    load_d = 1'b0;
                    if (avail_cnt_q == '0) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        target_d = lfsr_q[IDX_W:0];
                    end
                end else if (target_q < {1'b0, avail_cnt_q}) begin
                    pos_d   = '0;
                    state_d = SCAN;
                end else begin
                    target_d = target_q - {1'b0, avail_cnt_q};
                end
            end
            SCAN: begin
                // target < avail_cnt guarantees a hit before the end.
                pos_d = (pos_q == LAST) ? '0 : pos_q + I_ONE;
                if (pool_q[pos_q]) begin
                    if (target_q == '0) begin
                        card_valid_d  = 1'b1;
                        card_idx_d    = pos_q;
                        pool_d[pos_q] = 1'b0;
                        avail_cnt_d   = avail_cnt_q - I_ONE;
                        remaining_d   = remaining_q - C_ONE;
                        if (remaining_q == C_ONE) begin
                            state_d = FIN;
                        end else begin
                            load_d  = 1'b1;
                            state_d = MOD;
                        end
                    end else begin
                        target_d = target_q - T_ONE;
                    end
                end
            end
            FIN: begin
                done_d      = 1'b1;
                empty_err_d = err_q;
                err_d       = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Peer-board reset aborts the request with no further pulses.
        if (interboard_rst) begin
            state_d      = IDLE;
            pool_d       = '0;
            remaining_d  = '0;
            avail_cnt_d  = '0;
            target_d     = '0;
            pos_d        = '0;
            load_d       = 1'b0;
            err_d        = 1'b0;
            lfsr_d       = SEED;
            card_valid_d = 1'b0;
            card_idx_d   = '1;
            done_d       = 1'b0;
            empty_err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pool_q       <= '0;
            remaining_q  <= '0;
            avail_cnt_q  <= '0;
            target_q     <= '0;
            pos_q        <= '0;
            load_q       <= 1'b0;
            err_q        <= 1'b0;
            lfsr_q       <= SEED;
            card_valid_q <= 1'b0;
            card_idx_q   <= '1;
            done_q       <= 1'b0;
            empty_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pool_q       <= pool_d;
            remaining_q  <= remaining_d;
            avail_cnt_q  <= avail_cnt_d;
            target_q     <= target_d;
            pos_q        <= pos_d;
            load_q       <= load_d;
            err_q        <= err_d;
            lfsr_q       <= lfsr_d;
            card_valid_q <= card_valid_d;
            card_idx_q   <= card_idx_d;
            done_q       <= done_d;
            empty_err_q  <= empty_err_d;
        end
    end

    assign ready      = (state_q == IDLE);
    assign card_valid = card_valid_q;
    assign card_idx   = card_idx_q;
    assign done       = done_q;
    assign empty_err  = empty_err_q;

endmodule

// File: tb/tb_card_draw_multi.sv
// Testbench for card_draw_multi: directed and random draw requests
// checked against a cycle-level reference of the draw rules.
module tb_card_draw_multi;

    localparam int          N    = 106;
    localparam logic [15:0] SEED = 16'hACE1;

    logic           clk;
    logic           rst;
    logic           interboard_rst;
    logic           draw_req;
    logic [3:0]     draw_cnt;
    logic [N-1:0]   available_card;
    logic           ready;
    logic           card_valid;
    logic [6:0]     card_idx;
    logic           done;
    logic           empty_err;
`ifdef DRAW_SEED_LOAD_EN
    logic           seed_load;
    logic [15:0]    seed_val;
`endif

    card_draw_multi dut (
        .clk            (clk),
        .rst            (rst),
        .interboard_rst (interboard_rst),
        .draw_req       (draw_req),
        .draw_cnt       (draw_cnt),
        .available_card (available_card),
`ifdef DRAW_SEED_LOAD_EN
        .seed_load      (seed_load),
        .seed_val       (seed_val),
`endif
        .ready          (ready),
        .card_valid     (card_valid),
        .card_idx       (card_idx),
        .done           (done),
        .empty_err      (empty_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[14] ^ v[12] ^ v[3]};
    endfunction

    function automatic logic [15:0] ladv(input logic [15:0] v, input int n);
        logic [15:0] x;
        x = v;
        for (int i = 0; i < n; i++) x = lstep(x);
        return x;
    endfunction

    // Reference random source: the LFSR value seen in each cycle.
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else if (interboard_rst) m_lfsr <= SEED;
`ifdef DRAW_SEED_LOAD_EN
        else if (seed_load) m_lfsr <= (seed_val == 16'h0) ? SEED : seed_val;
`endif
        else m_lfsr <= lstep(m_lfsr);
    end

    int          obs_v_t[$];
    logic [31:0] obs_v_i[$];
    int          obs_d_t[$];
    logic [31:0] obs_d_e[$];

    always @(negedge clk) begin
        if (card_valid === 1'b1) begin
            obs_v_t.push_back(cyc);
            obs_v_i.push_back({25'b0, card_idx});
        end
        if (done === 1'b1) begin
            obs_d_t.push_back(cyc);
            obs_d_e.push_back({31'b0, empty_err});
        end
    end

    task automatic clear_obs();
        obs_v_t.delete();
        obs_v_i.delete();
        obs_d_t.delete();
        obs_d_e.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected events, in cycles counted from the cycle after the
    // draw_req sampling edge (cycle 0 is the first COUNT cycle).
    int exp_t[$];
    int exp_i[$];
    int exp_done_t;
    int exp_err;
    int exp_scan0;

    task automatic predict(input logic [N-1:0] pool_in, input int cnt,
                           input logic [15:0] lf);
        logic [N-1:0] p;
        logic [15:0]  l;
        int a, t, k, r, tg, pos, seen;
        p = pool_in;
        exp_t.delete();
        exp_i.delete();
        exp_err   = 0;
        exp_scan0 = -1;
        a = $countones(p);
        if (cnt == 0) begin
            exp_done_t = 1;
            return;
        end
        t = N;
        for (int d = 0; d < cnt; d++) begin
            if (a == 0) begin
                exp_err = 1;
                t = t + 1;
                break;
            end
            l   = ladv(lf, t + 1);
            tg  = int'(l[7:0]);
            k   = tg / a;
            r   = tg % a;
            pos = 0;
            seen = 0;
            for (int i = 0; i < N; i++) begin
                if (p[i]) begin
                    if (seen == r) begin
                        pos = i;
                        break;
                    end
                    seen++;
                end
            end
            if (exp_scan0 < 0) exp_scan0 = t + k + 2;
            t = t + k + 3 + pos;
            exp_t.push_back(t);
            exp_i.push_back(pos);
            p[pos] = 1'b0;
            a--;
        end
        exp_done_t = t + 1;
    endtask

    task automatic check_req(input string tag, input int c0);
        int n;
        chk({tag, ":ncard"}, obs_v_t.size(), exp_t.size());
        n = (obs_v_t.size() < exp_t.size()) ? obs_v_t.size() : exp_t.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s:t%0d", tag, i), obs_v_t[i] - c0 - 1, exp_t[i]);
            chk($sformatf("%s:idx%0d", tag, i), obs_v_i[i], exp_i[i]);
        end
        chk({tag, ":ndone"}, obs_d_t.size(), 1);
        if (obs_d_t.size() > 0) begin
            chk({tag, ":tdone"}, obs_d_t[0] - c0 - 1, exp_done_t);
            chk({tag, ":err"}, obs_d_e[0], exp_err);
        end
        chk({tag, ":ready"}, ready, 1);
    endtask

    task automatic run_req(input logic [N-1:0] pool_in, input int cnt,
                           input string tag, input bit poke);
        int c0, w;
        @(negedge clk);
        clear_obs();
        c0 = cyc;
        predict(pool_in, cnt, m_lfsr);
        draw_req       = 1'b1;
        draw_cnt       = 4'(cnt);
        available_card = pool_in;
        @(negedge clk);
        draw_req       = 1'b0;
        available_card = ~pool_in;
        if (poke) begin
            repeat (4) @(negedge clk);
            draw_req       = 1'b1;
            draw_cnt       = 4'd1;
            available_card = '1;
            @(negedge clk);
            draw_req = 1'b0;
        end
        w = 0;
        while (obs_d_t.size() == 0 && w < 9000) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        check_req(tag, c0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] pl;
    int           c0, w;
    logic [31:0]  s1[$];

    initial begin
        rst            = 1'b1;
        interboard_rst = 1'b0;
        draw_req       = 1'b0;
        draw_cnt       = 4'd0;
        available_card = '0;
`ifdef DRAW_SEED_LOAD_EN
        seed_load = 1'b0;
        seed_val  = 16'h0;
`endif
        #12;
        chk("rst:ready", ready, 1);
        chk("rst:idx", {25'b0, card_idx}, 32'h7F);
        chk("rst:valid", card_valid, 0);
        chk("rst:done", done, 0);
        chk("rst:err", empty_err, 0);
        chk("rst:lfsr", dut.lfsr_q, SEED);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        pl = '0;
        pl[42] = 1'b1;
        run_req(pl, 1, "single", 1'b1);

        pl = '0;
        pl[3] = 1'b1;
        pl[50] = 1'b1;
        pl[105] = 1'b1;
        run_req(pl, 3, "multi", 1'b0);

        pl = '0;
        pl[7] = 1'b1;
        run_req(pl, 2, "exhaust", 1'b0);

        run_req('1, 0, "zero", 1'b0);
        run_req('1, 14, "hand", 1'b0);

        // Asynchronous reset in the middle of a request.
        @(negedge clk);
        clear_obs();
        draw_req       = 1'b1;
        draw_cnt       = 4'd14;
        available_card = '1;
        @(negedge clk);
        draw_req = 1'b0;
        w = 0;
        while (obs_v_t.size() == 0 && w < 9000) begin
            @(negedge clk);
            w++;
        end
        chk("arst:card_seen", {31'b0, obs_v_t.size() > 0}, 1);
        chk("arst:busy", ready, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst:ready", ready, 1);
        chk("arst:idx", {25'b0, card_idx}, 32'h7F);
        chk("arst:valid", card_valid, 0);
        chk("arst:done", done, 0);
        chk("arst:err", empty_err, 0);
        chk("arst:lfsr", dut.lfsr_q, SEED);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Peer-board reset during the first SCAN of a 5-card request.
        pl = '1;
        @(negedge clk);
        clear_obs();
        c0 = cyc;
        predict(pl, 5, m_lfsr);
        draw_req       = 1'b1;
        draw_cnt       = 4'd5;
        available_card = pl;
        @(negedge clk);
        draw_req = 1'b0;
        w = 0;
        while (cyc != c0 + 1 + exp_scan0 && w < 9000) begin
            @(negedge clk);
            w++;
        end
        chk("abort:busy", ready, 0);
        interboard_rst = 1'b1;
        @(negedge clk);
        interboard_rst = 1'b0;
        chk("abort:ready", ready, 1);
        chk("abort:idx", {25'b0, card_idx}, 32'h7F);
        chk("abort:valid", card_valid, 0);
        chk("abort:done", done, 0);
        repeat (700) @(negedge clk);
        chk("abort:ncard", obs_v_t.size(), 0);
        chk("abort:ndone", obs_d_t.size(), 0);

        run_req('1, 4, "post_abort", 1'b0);

        for (int r = 0; r < 6; r++) begin
            pl = '0;
            for (int b = 0; b < N; b++) begin
                if (r % 2 == 0) pl[b] = ($urandom_range(0, 15) == 0);
                else pl[b] = 1'($urandom_range(0, 1));
            end
            run_req(pl, int'($urandom_range(0, 15)),
                    $sformatf("rnd%0d", r), 1'b0);
        end

`ifdef DRAW_SEED_LOAD_EN
        @(negedge clk);
        seed_load = 1'b1;
        seed_val  = 16'h0;
        @(negedge clk);
        seed_load = 1'b0;
        chk("seed0:lfsr", dut.lfsr_q, SEED);

        @(negedge clk);
        seed_load = 1'b1;
        seed_val  = 16'h1234;
        @(negedge clk);
        seed_load = 1'b0;
        run_req('1, 14, "seedA", 1'b0);
        s1 = obs_v_i;

        @(negedge clk);
        seed_load = 1'b1;
        seed_val  = 16'h1234;
        @(negedge clk);
        seed_load = 1'b0;
        run_req('1, 14, "seedB", 1'b0);
        chk("seed:len", obs_v_i.size(), 14);
        chk("seed:len_ref", s1.size(), 14);
        for (int i = 0; i < 14; i++) begin
            if (i < s1.size() && i < obs_v_i.size()) begin
                chk($sformatf("seed:same%0d", i), obs_v_i[i], s1[i]);
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
